// File: rtl/xg_ifetch_queue_pkg.sv
// Shared types and constants for the xgriscv instruction-fetch queue.
// The width/reset-PC macros mirror the shared xgriscv_defines.v include; the
// guards keep a project-wide definition authoritative when one is present.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef XG_RESET_PC
`define XG_RESET_PC 32'h0000_0000
`endif

package xg_ifetch_queue_pkg;

  localparam int unsigned ADDR_W  = `ADDR_SIZE;
  localparam int unsigned INSTR_W = `INSTR_SIZE;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // One queued fetch: pc in the upper half, instruction word in the lower.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/xg_ifq_fifo.sv
// Circular buffer behind the fetch queue.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, wdata       write wdata at the tail (ignored when full without pop, or on flush)
//   pop               retire the head entry (ignored when empty)
//   flush             empty the queue: rd_ptr catches up with wr_ptr
//   rdata             head entry (undefined when empty; caller gates it)
//   count, empty,full occupancy
module xg_ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_next;
  logic             push_ok, pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop frees the head slot in the same cycle, so a full queue may still accept.
  assign push_ok = push & ~flush & (~full | pop);
  assign pop_ok  = pop & ~empty;

  assign rdata = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/xg_ifetch_queue.sv
// Instruction-fetch front end for the xgriscv pipeline: sequential fetch PC
// driving an asynchronous-read imem, a small {pc, instr} queue toward decode
// with a valid/ready handshake, and flush/restart on branch/jal/jalr redirect.
// Optional feature macro: XG_IFQ_STATS_EN adds stat_stall_cnt/stat_flush_cnt.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   imem_addr / imem_rdata     fetch address out, same-cycle instruction in
//   out_valid/out_ready        handshake to decode; out_pc/out_instr = head entry
//   redirect_valid/redirect_pc flush and restart fetch at the aligned target
//   q_count                    occupied entries
//   stat_stall_cnt             (stats build) cycles with out_valid & ~out_ready
//   stat_flush_cnt             (stats build) cycles with redirect_valid
module xg_ifetch_queue
  import xg_ifetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = `XG_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] q_count
`ifdef XG_IFQ_STATS_EN
  ,
  output logic [31:0]            stat_stall_cnt,
  output logic [31:0]            stat_flush_cnt
`endif
);

  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
  logic              pop, push, fetch_en;
  logic              q_empty, q_full;
  ifq_entry_t        head, tail;

  assign imem_addr = fetch_pc;
  assign out_valid = ~q_empty;
  assign pop       = out_valid & out_ready;
  assign fetch_en  = ~q_full | pop;
  // The word fetched in a redirect cycle belongs to the wrong path.
  assign push      = fetch_en & ~redirect_valid;

  assign tail.pc    = fetch_pc;
  assign tail.instr = imem_rdata;

  // Gate the head so an empty queue presents zeros rather than stale entries.
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next = align_pc(redirect_pc);
    end else if (fetch_en) begin
      fetch_pc_next = fetch_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_next;
    end
  end

  xg_ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (tail),
    .rdata (head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

`ifdef XG_IFQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (redirect_valid)          stat_flush_cnt <= stat_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xg_ifetch_queue.sv
// Directed self-checking bench for xg_ifetch_queue (DEPTH=4, RESET_PC=0).
module tb_xg_ifetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  q_count;
`ifdef XG_IFQ_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic use_pattern;

  xg_ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .q_count        (q_count)
`ifdef XG_IFQ_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read imem: nop everywhere, or an address-tagged word.
  always_comb begin
    imem_rdata = 32'h0000_0013;
    if (use_pattern) imem_rdata = imem_addr ^ 32'hDEAD_0000;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    use_pattern    = 1'b0;

    // Reset state
    #2;
    chk("rst_imem_addr", 64'(imem_addr), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_q_count",   64'(q_count),   64'h0);
    chk("rst_out_pc",    64'(out_pc),    64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'h0);
`ifdef XG_IFQ_STATS_EN
    chk("rst_stall", 64'(stat_stall_cnt), 64'h0);
    chk("rst_flush", 64'(stat_flush_cnt), 64'h0);
`endif

    // 1. Streaming at one instruction per cycle
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t1_first_addr",  64'(imem_addr), 64'h0);
    chk("t1_first_valid", 64'(out_valid), 64'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid",   64'(out_valid), 64'h1);
      chk("t1_out_pc",  64'(out_pc),    64'(4 * k));
      chk("t1_addr",    64'(imem_addr), 64'(4 * k + 4));
      chk("t1_count",   64'(q_count),   64'h1);
      chk("t1_instr",   64'(out_instr), 64'h13);
      step();
    end

    // Asynchronous reset mid-stream, then 2. decode stalls for 10 cycles
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_addr",  64'(imem_addr), 64'h0);
    chk("mid_rst_count", 64'(q_count),   64'h0);
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step();
    chk("t2_count_mid", 64'(q_count),   64'h2);
    chk("t2_addr_mid",  64'(imem_addr), 64'h8);
    repeat (8) step();
    chk("t2_count_full", 64'(q_count),   64'h4);
    chk("t2_addr_frozen", 64'(imem_addr), 64'h10);
    chk("t2_out_pc_hold", 64'(out_pc),    64'h0);
    chk("t2_valid",      64'(out_valid), 64'h1);
`ifdef XG_IFQ_STATS_EN
    chk("t2_stall_cnt", 64'(stat_stall_cnt), 64'd9);
`endif

    // 3. One pop from a full queue: one push, count unchanged
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_count",  64'(q_count),   64'h4);
    chk("t3_addr",   64'(imem_addr), 64'h14);
    chk("t3_out_pc", 64'(out_pc),    64'h4);
    step();
    chk("t3_hold_count", 64'(q_count),   64'h4);
    chk("t3_hold_addr",  64'(imem_addr), 64'h14);
    chk("t3_hold_pc",    64'(out_pc),    64'h4);

    // 5. Back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    chk("t5_r1_count", 64'(q_count),   64'h0);
    chk("t5_r1_valid", 64'(out_valid), 64'h0);
    chk("t5_r1_addr",  64'(imem_addr), 64'h200);
    redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    chk("t5_r2_count", 64'(q_count),   64'h0);
    chk("t5_r2_valid", 64'(out_valid), 64'h0);
    chk("t5_r2_addr",  64'(imem_addr), 64'h300);
    step();
    chk("t5_first_pc", 64'(out_pc),  64'h300);
    chk("t5_count1",   64'(q_count), 64'h1);
    repeat (2) step();
    chk("t5_count3", 64'(q_count),   64'h3);
    chk("t5_addr",   64'(imem_addr), 64'h30C);
    chk("t5_head",   64'(out_pc),    64'h300);

    // 4. Redirect with q_count=3 and a pop in the same cycle
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("t4_count", 64'(q_count),   64'h0);
    chk("t4_valid", 64'(out_valid), 64'h0);
    chk("t4_addr",  64'(imem_addr), 64'h100);
    step();
    chk("t4_out_pc", 64'(out_pc),    64'h100);
    chk("t4_valid2", 64'(out_valid), 64'h1);
    chk("t4_addr2",  64'(imem_addr), 64'h104);
`ifdef XG_IFQ_STATS_EN
    chk("t4_stall_cnt", 64'(stat_stall_cnt), 64'd13);
    chk("t4_flush_cnt", 64'(stat_flush_cnt), 64'd3);
`endif

    // 6. fetch_pc wraps past 0xFFFF_FFFC; redirect low bits ignored
    use_pattern    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("t6_addr_top", 64'(imem_addr), 64'hFFFF_FFFC);
    step();
    chk("t6_addr_wrap", 64'(imem_addr), 64'h0);
    chk("t6_pc_top",    64'(out_pc),    64'hFFFF_FFFC);
    chk("t6_instr_top", 64'(out_instr), 64'h2152_FFFC);
    step();
    chk("t6_pc_zero",    64'(out_pc),    64'h0);
    chk("t6_instr_zero", 64'(out_instr), 64'hDEAD_0000);
    chk("t6_addr_four",  64'(imem_addr), 64'h4);

    // Reset mid-stream takes effect without a clock edge
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'h0);
    chk("t6_rst_addr",  64'(imem_addr), 64'h0);
    chk("t6_rst_count", 64'(q_count),   64'h0);
    chk("t6_rst_pc",    64'(out_pc),    64'h0);
`ifdef XG_IFQ_STATS_EN
    chk("t6_rst_stall", 64'(stat_stall_cnt), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
